// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared types and helpers for the Game of Life engine.
//   state_t   : engine control states (IDLE, CALC, SWAP)
//   W/H/SIZE  : board geometry for the default 8x8 build
//   POP_BITS  : width needed to hold a population count of SIZE
//   xy_to_idx : linear cell index, y*W + x, for a board of width 2**bit_w
// -----------------------------------------------------------------------------
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SWAP = 2'd2
  } state_t;

  localparam int unsigned DEF_BIT_W = 3;
  localparam int unsigned DEF_BIT_H = 3;
  localparam int unsigned W         = 1 << DEF_BIT_W;
  localparam int unsigned H         = 1 << DEF_BIT_H;
  localparam int unsigned SIZE      = W * H;
  localparam int unsigned POP_BITS  = DEF_BIT_W + DEF_BIT_H + 1;

  // Row-major index. Because W is a power of two this is a plain
  // concatenation {y, x} once truncated to BIT_W+BIT_H bits.
  function automatic int unsigned xy_to_idx(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned bit_w);
    return (y << bit_w) | x;
  endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// -----------------------------------------------------------------------------
// life_neighbour_count
// Counts live cells among the 8 neighbours of (x, y). Purely combinational.
//   board : full board, bit index y*W + x
//   x, y  : cell coordinates
//   count : 0..8
// WRAP=0 treats cells beyond the edges as dead; WRAP=1 wraps both axes
// (torus), which falls out of letting the coordinate arithmetic truncate.
// -----------------------------------------------------------------------------
module life_neighbour_count
  import life_pkg::*;
#(
  parameter int BIT_W = 3,
  parameter int BIT_H = 3,
  parameter int WRAP  = 0
) (
  input  logic [(1 << (BIT_W + BIT_H))-1:0] board,
  input  logic [BIT_W-1:0]                  x,
  input  logic [BIT_H-1:0]                  y,
  output logic [3:0]                        count
);

  localparam int IDX_W = BIT_W + BIT_H;

  // One entry per 3x3 position; entry 4 is the cell itself and stays 0.
  logic [8:0] near;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_nb
      if (gi == 4) begin : g_self
        assign near[gi] = 1'b0;
      end else begin : g_other
        localparam int DX = (gi % 3) - 1;
        localparam int DY = (gi / 3) - 1;

        logic [BIT_W-1:0] nx;
        logic [BIT_H-1:0] ny;
        logic             in_x;
        logic             in_y;
        logic [IDX_W-1:0] nidx;

        // Adding the all-ones pattern of -1 wraps naturally at the edges.
        assign nx   = x + BIT_W'(DX);
        assign ny   = y + BIT_H'(DY);
        assign in_x = (DX == 0) ? 1'b1 : (DX < 0) ? (x != '0) : (x != '1);
        assign in_y = (DY == 0) ? 1'b1 : (DY < 0) ? (y != '0) : (y != '1);
        assign nidx = IDX_W'(xy_to_idx(32'(nx), 32'(ny), BIT_W));

        if (WRAP != 0) begin : g_torus
          assign near[gi] = board[nidx];
        end else begin : g_flat
          assign near[gi] = in_x && in_y && board[nidx];
        end
      end
    end
  endgenerate

  always_comb begin
    count = 4'd0;
    for (int k = 0; k < 9; k++) begin
      count = count + {3'b000, near[k]};
    end
  end

endmodule

// File: rtl/life_engine_gen2.sv
// -----------------------------------------------------------------------------
// life_engine_gen2
// Double-buffered Conway Game of Life engine running on the pixel clock.
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   frame_tick  : one-cycle pulse per frame
//   run, rate   : auto-advance every rate+1 frame ticks while run is high
//   step        : one-cycle request for a single generation
//   load, seed  : one-cycle request to copy seed into the displayed board
//   rd_x, rd_y  : display read address; rd_cell is the displayed cell
//   busy        : a generation is being computed or swapped in
//   gen_count   : generations since last load/reset (wraps)
//   population  : live cells in the displayed board
//   stable      : last generation equal to its predecessor
//   extinct     : population is zero
// One cell is evaluated per cycle from the front board into the back board;
// a final SWAP cycle flips the boards so the display never sees a partial
// generation.
// -----------------------------------------------------------------------------
module life_engine_gen2
  import life_pkg::*;
#(
  parameter int BIT_W    = DEF_BIT_W,
  parameter int BIT_H    = DEF_BIT_H,
  parameter int WRAP     = 0,
  parameter int GEN_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_tick,
  input  logic                              run,
  input  logic                              step,
  input  logic [3:0]                        rate,
  input  logic                              load,
  input  logic [(1 << (BIT_W + BIT_H))-1:0] seed,
  input  logic [BIT_W-1:0]                  rd_x,
  input  logic [BIT_H-1:0]                  rd_y,
  output logic                              rd_cell,
  output logic                              busy,
  output logic [GEN_BITS-1:0]               gen_count,
  output logic [BIT_W+BIT_H:0]              population,
  output logic                              stable,
  output logic                              extinct
);

  localparam int IDX_W = BIT_W + BIT_H;
  localparam int CELLS = 1 << IDX_W;
  localparam int POP_W = IDX_W + 1;

  state_t              state_reg, state_next;
  logic [CELLS-1:0]    board_a_reg, board_b_reg;
  logic                front_sel_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [3:0]          rate_cnt_reg;
  logic [GEN_BITS-1:0] gen_count_reg;
  logic [POP_W-1:0]    pop_reg;
  logic [POP_W-1:0]    pop_acc_reg;
  logic                diff_reg;
  logic                stable_reg;

  logic [CELLS-1:0]    front;
  logic [3:0]          nb_count;
  logic                cur_alive;
  logic                next_alive;
  logic                last_cell;
  logic                rate_hit;
  logic                load_ok;
  logic                start;
  logic [IDX_W-1:0]    rd_idx;

  assign front     = front_sel_reg ? board_b_reg : board_a_reg;
  assign cur_alive = front[idx_reg];
  assign last_cell = &idx_reg;
  assign rate_hit  = (rate_cnt_reg == rate);

  // A load landing on the SWAP cycle is dropped so the swap is never torn.
  assign load_ok = load && (state_reg != SWAP);

  life_neighbour_count #(
    .BIT_W (BIT_W),
    .BIT_H (BIT_H),
    .WRAP  (WRAP)
  ) u_nb (
    .board (front),
    .x     (idx_reg[BIT_W-1:0]),
    .y     (idx_reg[IDX_W-1:BIT_W]),
    .count (nb_count)
  );

  assign next_alive = (cur_alive && (nb_count == 4'd2 || nb_count == 4'd3)) ||
                      (!cur_alive && nb_count == 4'd3);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!load && (step || (run && frame_tick && rate_hit))) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (load) begin
          state_next = IDLE;
        end else if (last_cell) begin
          state_next = SWAP;
        end
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign start = (state_reg == IDLE) && (state_next == CALC);

  // ---------------------------------------------------------------------------
  // Boards, counters and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_a_reg   <= '0;
      board_b_reg   <= '0;
      front_sel_reg <= 1'b0;
      idx_reg       <= '0;
      rate_cnt_reg  <= '0;
      gen_count_reg <= '0;
      pop_reg       <= '0;
      pop_acc_reg   <= '0;
      diff_reg      <= 1'b0;
      stable_reg    <= 1'b0;
    end else if (load_ok) begin
      // Load wins in IDLE and aborts CALC; the half-written back board is
      // simply overwritten by the next generation.
      if (front_sel_reg) begin
        board_b_reg <= seed;
      end else begin
        board_a_reg <= seed;
      end
      gen_count_reg <= '0;
      pop_reg       <= POP_W'($countones(seed));
      stable_reg    <= 1'b0;
      rate_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg     <= '0;
            pop_acc_reg <= '0;
            diff_reg    <= 1'b0;
          end
          // Ticks only reach the divider when no step pre-empts them. A
          // counter left above a freshly lowered rate restarts from zero
          // rather than running all the way round.
          if (!step && run && frame_tick) begin
            if (rate_hit || (rate_cnt_reg > rate)) begin
              rate_cnt_reg <= '0;
            end else begin
              rate_cnt_reg <= rate_cnt_reg + 4'd1;
            end
          end
        end
        CALC: begin
          if (front_sel_reg) begin
            board_a_reg[idx_reg] <= next_alive;
          end else begin
            board_b_reg[idx_reg] <= next_alive;
          end
          idx_reg     <= idx_reg + IDX_W'(1);
          pop_acc_reg <= pop_acc_reg + POP_W'(next_alive);
          diff_reg    <= diff_reg | (next_alive != cur_alive);
        end
        SWAP: begin
          front_sel_reg <= ~front_sel_reg;
          gen_count_reg <= gen_count_reg + GEN_BITS'(1);
          pop_reg       <= pop_acc_reg;
          stable_reg    <= ~diff_reg;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_idx     = IDX_W'(xy_to_idx(32'(rd_x), 32'(rd_y), BIT_W));
  assign rd_cell    = front[rd_idx];
  assign busy       = (state_reg != IDLE);
  assign gen_count  = gen_count_reg;
  assign population = pop_reg;
  assign stable     = stable_reg;
  assign extinct    = (pop_reg == '0);

endmodule

// File: tb/tb_life_engine_gen2.sv
// -----------------------------------------------------------------------------
// tb_life_engine_gen2
// Directed bench for life_engine_gen2 on an 8x8 board. Two engines share all
// inputs: u_flat (dead border) and u_torus (wrap-around), so each pattern is
// seen under both edge rules.
// -----------------------------------------------------------------------------
module tb_life_engine_gen2;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        run;
  logic        step;
  logic [3:0]  rate;
  logic        load;
  logic [63:0] seed;
  logic [2:0]  rd_x;
  logic [2:0]  rd_y;

  logic        rd_cell_f, rd_cell_t;
  logic        busy_f, busy_t;
  logic [15:0] gen_f, gen_t;
  logic [6:0]  pop_f, pop_t;
  logic        stable_f, stable_t;
  logic        extinct_f, extinct_t;

  int n_cmp = 0;
  int n_err = 0;

  life_engine_gen2 #(.BIT_W(3), .BIT_H(3), .WRAP(0), .GEN_BITS(16)) u_flat (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .run        (run),
    .step       (step),
    .rate       (rate),
    .load       (load),
    .seed       (seed),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_cell    (rd_cell_f),
    .busy       (busy_f),
    .gen_count  (gen_f),
    .population (pop_f),
    .stable     (stable_f),
    .extinct    (extinct_f)
  );

  life_engine_gen2 #(.BIT_W(3), .BIT_H(3), .WRAP(1), .GEN_BITS(16)) u_torus (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .run        (run),
    .step       (step),
    .rate       (rate),
    .load       (load),
    .seed       (seed),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_cell    (rd_cell_t),
    .busy       (busy_t),
    .gen_count  (gen_t),
    .population (pop_t),
    .stable     (stable_t),
    .extinct    (extinct_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] c(input int x, input int y);
    logic [63:0] v;
    v = 64'd1;
    return v << (y * 8 + x);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [63:0] v);
    @(posedge clk);
    #1;
    seed = v;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic do_step();
    @(posedge clk);
    #1;
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic do_tick();
    @(posedge clk);
    #1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  // Counts clock edges until busy drops; bounded so a stuck engine shows up
  // as a wrong cycle count instead of a hang.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_f && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic read_board(input bit torus, output logic [63:0] b);
    b = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rd_x = 3'(x);
        rd_y = 3'(y);
        #1;
        b[y*8+x] = torus ? rd_cell_t : rd_cell_f;
      end
    end
  endtask

  logic [63:0] blinker_v, blinker_h, edge_seed, block, glider, board;
  int          n;

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
    rate       = 4'd0;
    load       = 1'b0;
    seed       = '0;
    rd_x       = '0;
    rd_y       = '0;

    blinker_v = c(3,2) | c(3,3) | c(3,4);
    blinker_h = c(2,3) | c(3,3) | c(4,3);
    edge_seed = c(3,0) | c(4,0) | c(5,0);
    block     = c(1,1) | c(2,1) | c(1,2) | c(2,2);
    glider    = c(1,0) | c(2,1) | c(0,2) | c(1,2) | c(2,2);

    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Reset state
    chk("rst gen_count", 64'(gen_f), 64'd0);
    chk("rst population", 64'(pop_f), 64'd0);
    chk("rst extinct", 64'(extinct_f), 64'd1);
    chk("rst busy", 64'(busy_f), 64'd0);
    chk("rst stable", 64'(stable_f), 64'd0);
    read_board(1'b0, board);
    chk("rst board", board, 64'd0);

    // Blinker, dead border
    do_load(blinker_v);
    chk("blinker load pop", 64'(pop_f), 64'd3);
    chk("blinker load ext", 64'(extinct_f), 64'd0);
    do_step();
    chk("blinker busy start", 64'(busy_f), 64'd1);
    wait_idle(n);
    chk("blinker busy cycles", 64'(n), 64'd65);
    read_board(1'b0, board);
    chk("blinker board", board, blinker_h);
    chk("blinker pop", 64'(pop_f), 64'd3);
    chk("blinker gen", 64'(gen_f), 64'd1);
    chk("blinker stable", 64'(stable_f), 64'd0);
    chk("torus idle", 64'(busy_t), 64'd0);

    // Edge blinker under both rules
    do_load(edge_seed);
    do_step();
    wait_idle(n);
    read_board(1'b0, board);
    chk("edge flat board", board, c(4,0) | c(4,1));
    chk("edge flat pop", 64'(pop_f), 64'd2);
    read_board(1'b1, board);
    chk("edge torus board", board, c(4,7) | c(4,0) | c(4,1));
    chk("edge torus pop", 64'(pop_t), 64'd3);

    // Block still life
    do_load(block);
    do_step();
    wait_idle(n);
    read_board(1'b0, board);
    chk("block board", board, block);
    chk("block stable", 64'(stable_f), 64'd1);
    chk("block stable torus", 64'(stable_t), 64'd1);
    chk("block pop", 64'(pop_f), 64'd4);

    // Single cell dies
    do_load(c(4,4));
    chk("single load stable", 64'(stable_f), 64'd0);
    do_step();
    wait_idle(n);
    chk("single extinct", 64'(extinct_f), 64'd1);
    chk("single extinct torus", 64'(extinct_t), 64'd1);
    chk("single gen", 64'(gen_f), 64'd1);
    chk("single pop", 64'(pop_f), 64'd0);

    // Glider on the torus, one generation per tick
    do_load(glider);
    rate = 4'd0;
    run  = 1'b1;
    for (int g = 0; g < 32; g++) begin
      do_tick();
      wait_idle(n);
      chk($sformatf("glider pop g%0d", g + 1), 64'(pop_t), 64'd5);
    end
    run = 1'b0;
    read_board(1'b1, board);
    chk("glider board", board, glider);
    chk("glider gen", 64'(gen_t), 64'd32);

    // Divider: rate=2 advances on every third tick; a step during busy is lost
    do_load(blinker_v);
    rate = 4'd2;
    run  = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      do_tick();
      if (t == 3) begin
        cyc(10);
        chk("div busy at step", 64'(busy_f), 64'd1);
        do_step();
        cyc(86);
      end else begin
        cyc(98);
      end
    end
    run = 1'b0;
    chk("div gen", 64'(gen_f), 64'd3);
    chk("div busy end", 64'(busy_f), 64'd0);

    // Load aborts a computation in progress
    do_load(blinker_v);
    do_step();
    cyc(10);
    do_load(block);
    chk("abort busy", 64'(busy_f), 64'd0);
    read_board(1'b0, board);
    chk("abort board", board, block);
    chk("abort gen", 64'(gen_f), 64'd0);
    chk("abort pop", 64'(pop_f), 64'd4);

    // Asynchronous reset mid-computation
    do_load(blinker_v);
    do_step();
    wait_idle(n);
    chk("pre-reset gen", 64'(gen_f), 64'd1);
    do_step();
    cyc(20);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset busy", 64'(busy_f), 64'd0);
    chk("areset gen", 64'(gen_f), 64'd0);
    chk("areset pop", 64'(pop_f), 64'd0);
    chk("areset extinct", 64'(extinct_f), 64'd1);
    chk("areset stable", 64'(stable_f), 64'd0);
    read_board(1'b0, board);
    chk("areset board", board, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    chk("post-reset busy", 64'(busy_f), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/life_engine_gen2.md
Name: life_engine_gen2

Overview:
- Parametrised Conway Game of Life engine; successor to the fixed 8x8 vsync-clocked board logic.
- Runs entirely on the pixel clock. A frame-tick strobe replaces clocking on vsync.
- Double-buffered: the display port always shows a complete generation.
- Adds board-size generics, toroidal wrap mode, a speed divider, single-step, seed loading, population count and stable/extinct flags.
- Sits between vga_sync (frame tick, pixel coordinates) and the RGB colour mapping.

Parameters:
- BIT_W, 3, log2 board width; W = 2**BIT_W.
- BIT_H, 3, log2 board height; H = 2**BIT_H; SIZE = W*H.
- WRAP, 0, 0 = cells outside the board are dead; 1 = toroidal (indices mod W, mod H).
- GEN_BITS, 16, width of the generation counter.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per frame, from a vsync edge detect
- run  in  1  level; auto-advance on frame ticks
- step  in  1  one-cycle pulse; request one generation
- rate  in  4  advance every rate+1 frame ticks
- load  in  1  one-cycle pulse; copy seed into the front board
- seed  in  SIZE  seed pattern; bit index = y*W + x
- rd_x  in  BIT_W  display read column
- rd_y  in  BIT_H  display read row
- rd_cell  out  1  front[rd_y*W + rd_x]; combinational
- busy  out  1  high while state != IDLE
- gen_count  out  GEN_BITS  generations since last load or reset; wraps
- population  out  BIT_W+BIT_H+1  live cells in the front board
- stable  out  1  last generation identical to its predecessor
- extinct  out  1  population == 0

Behaviour:
- Storage:
  - Two SIZE-bit boards A and B; front_sel picks the displayed/source board.
  - Compute reads the front board and writes the back board only.
- Reset (async): both boards 0, front_sel=0, state IDLE, rate counter 0, gen_count 0, population 0, stable 0. extinct=1 follows from population 0.
- States: IDLE, CALC, SWAP.
- IDLE, in priority order:
  - load: front <= seed; gen_count 0; population <= popcount(seed); stable 0; rate counter 0; stay IDLE.
  - else step: go to CALC with i=0.
  - else run && frame_tick: if rate counter == rate, clear the counter and go to CALC with i=0; otherwise increment the counter.
- CALC:
  - One cell per cycle, i = 0..SIZE-1, x = i mod W, y = i / W.
  - Neighbour count is 0..8 over the 8 surrounding cells, using the WRAP rule.
  - Next cell = (alive && n in {2,3}) || (!alive && n == 3).
  - Write back[i]; accumulate popcount and a diff flag (any cell changed).
  - At i == SIZE-1, go to SWAP.
- SWAP (one cycle):
  - Toggle front_sel; gen_count++; population <= accumulated count; stable <= !diff.
  - Return to IDLE.
- Latency:
  - Trigger accepted at edge t0; cell i is written at edge t0+1+i.
  - SWAP at edge t0+SIZE+1; rd_cell shows the new generation from t0+SIZE+1 onward.
  - busy is high for exactly SIZE+1 cycles.
- Concurrent events:
  - step or frame_tick while busy: ignored, not queued. The rate counter does not count ticks while busy.
  - load in CALC: aborts the computation, applies the load as in IDLE, next state IDLE.
  - load in SWAP: the swap completes first; the load is dropped.
- rate changes take effect at the next tick comparison. A counter already above the new rate is reset to 0 on the next tick.
- Reset mid-CALC: immediate return to reset values; the partial back board is discarded.
- Arithmetic: neighbour count 4 bits; popcount accumulator BIT_W+BIT_H+1 bits (holds SIZE). Index math is done in the unsigned widths above; wrap uses natural truncation.

Decomposition:
- Package life_pkg:
  - state enum {IDLE, CALC, SWAP}.
  - Derived constants W, H, SIZE, POP_BITS.
  - xy_to_idx function.
- Sub-module life_neighbour_count (params BIT_W, BIT_H, WRAP):
  - Inputs: board vector, x, y.
  - Output: 4-bit count. Purely combinational.

Test Plan:
- Blinker, WRAP=0, 8x8: seed (3,2),(3,3),(3,4); load; step -> after 66 cycles front = (2,3),(3,3),(4,3); population 3; gen_count 1; stable 0.
- Edge blinker, seed (3,0),(4,0),(5,0):
  - WRAP=0: step -> (4,0),(4,1); population 2.
  - WRAP=1: step -> (4,7),(4,0),(4,1); population 3.
- Glider, WRAP=1, run=1, rate=0: after 32 generations the board equals the seed; gen_count 32; population 5 throughout.
- Block 2x2 at (1,1): step -> identical board; stable 1; population 4. Single cell: step -> extinct 1; gen_count 1.
- Divider: run=1, rate=2, frame_tick every 100 cycles for 9 ticks -> gen_count 3; step pulsed during busy -> gen_count unchanged by it.
- Abort and reset:
  - load pulsed at CALC cycle 10 -> busy low next cycle; front = seed; gen_count 0.
  - rst_n low mid-CALC -> all outputs at reset values asynchronously; rd_cell 0.
